// File: rtl/pixel_dma_out_frame_sequencer.sv
// pixel_dma_out_frame_sequencer: drives the pixel_dma_out ap_ctrl_hs handshake one frame at a time, with watchdog, deadlock qualification and soft-reset recovery
//   ap_clk/ap_rst_n                    clock, async active-low reset
//   enable, frame_limit                run request, frames per run (0 = continuous)
//   timeout_cycles                     per-frame watchdog limit (0 = off)
//   clear_fault                        releases FAULT
//   core_ap_start/ready/done/idle      ap_ctrl_hs handshake with the core
//   deadlock_block                     deadlock monitor block flag
//   core_rst_n                         soft reset to the core
//   busy, frames_done, fault, fault_cause, error_count   status
module pixel_dma_out_frame_sequencer #(
  parameter int TIMEOUT_W  = 24,
  parameter int BLOCK_HOLD = 16,
  parameter int RST_CYCLES = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 enable,
  input  logic [15:0]          frame_limit,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 clear_fault,
  output logic                 core_ap_start,
  input  logic                 core_ap_ready,
  input  logic                 core_ap_done,
  input  logic                 core_ap_idle,
  input  logic                 deadlock_block,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic [15:0]          frames_done,
  output logic                 fault,
  output logic [1:0]           fault_cause,
  output logic [7:0]           error_count
);
  localparam int BW = $clog2(BLOCK_HOLD + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [BW-1:0] HOLD  = BW'(BLOCK_HOLD);
  localparam logic [RW-1:0] RLAST = RW'(RST_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, START, RUN, RECOVER, FAULT} state_t;
  state_t               state_q;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [BW-1:0]        blk_q, blk_d;
  logic [RW-1:0]        rcnt_q;
  logic [15:0]          frames_q, frames_d;
  logic [1:0]           cause_q;
  logic [7:0]           err_q;
  logic                 start_q, rst_q, busy_q, fault_q;
  logic                 active, done_ev, to_fire, dl_fire, limit_hit;
  // wdog_d is the count including the current cycle, so the watchdog fires on the Nth cycle after START entry
  always_comb begin
    active    = state_q == START || state_q == RUN;
    wdog_d    = wdog_q + 1'b1;
    frames_d  = frames_q + 1'b1;
    to_fire   = active && timeout_cycles != '0 && wdog_d == timeout_cycles;
    dl_fire   = active && deadlock_block && blk_q >= HOLD - 1'b1;
    blk_d     = !deadlock_block ? '0 : dl_fire ? HOLD : blk_q + 1'b1;
    done_ev   = core_ap_done && (state_q == RUN || (state_q == START && core_ap_ready));
    limit_hit = frame_limit != '0 && frames_d == frame_limit;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      rst_q    <= 1'b1;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
      frames_q <= '0;
      cause_q  <= '0;
      err_q    <= '0;
      wdog_q   <= '0;
      blk_q    <= '0;
      rcnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (enable && core_ap_idle) begin
          state_q  <= START;
          start_q  <= 1'b1;
          busy_q   <= 1'b1;
          frames_q <= '0;
          wdog_q   <= '0;
          blk_q    <= '0;
        end
        START, RUN: begin
          wdog_q <= wdog_d;
          blk_q  <= blk_d;
          // a done in the same cycle as a fault event wins: the frame counts and no fault is raised
          if (done_ev) begin
            frames_q <= frames_d;
            if (limit_hit || !enable) begin
              state_q <= IDLE;
              start_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= START;
              start_q <= 1'b1;
              wdog_q  <= '0;
            end
          end else if (to_fire || dl_fire) begin
            state_q <= RECOVER;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            rst_q   <= 1'b0;
            rcnt_q  <= '0;
            cause_q <= {dl_fire, to_fire};
            err_q   <= err_q + {7'd0, err_q != 8'hff};
          end else if (state_q == START && core_ap_ready) begin
            state_q <= RUN;
            start_q <= 1'b0;
          end
        end
        RECOVER: if (rcnt_q == RLAST) begin
          state_q <= FAULT;
          rst_q   <= 1'b1;
        end else begin
          rcnt_q <= rcnt_q + 1'b1;
        end
        FAULT: if (clear_fault) begin
          state_q <= IDLE;
          fault_q <= 1'b0;
          cause_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign core_ap_start = start_q;
  assign core_rst_n    = rst_q;
  assign busy          = busy_q;
  assign frames_done   = frames_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign error_count   = err_q;
endmodule

// File: tb/tb_pixel_dma_out_frame_sequencer.sv
// tb_pixel_dma_out_frame_sequencer: directed checks of frame sequencing, watchdog, deadlock qualification, recovery and reset
module tb_pixel_dma_out_frame_sequencer;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n, enable, clear_fault, deadlock_block;
  logic        core_ap_ready = 1'b0, core_ap_done = 1'b0, core_ap_idle;
  logic        core_ap_start, core_rst_n, busy, fault;
  logic [15:0] frame_limit, frames_done;
  logic [23:0] timeout_cycles;
  logic [1:0]  fault_cause;
  logic [7:0]  error_count;
  int          n_cmp = 0, n_err = 0, exp_err = 0;
  int          rdy_dly = 2, done_dly = 20;
  logic        never_done = 1'b0;
  logic        mbusy = 1'b0;
  int          cnt = 0, start_cnt = 0;
  int          exp_q[$];
  pixel_dma_out_frame_sequencer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .frame_limit(frame_limit),
    .timeout_cycles(timeout_cycles), .clear_fault(clear_fault), .core_ap_start(core_ap_start),
    .core_ap_ready(core_ap_ready), .core_ap_done(core_ap_done), .core_ap_idle(core_ap_idle),
    .deadlock_block(deadlock_block), .core_rst_n(core_rst_n), .busy(busy), .frames_done(frames_done),
    .fault(fault), .fault_cause(fault_cause), .error_count(error_count)
  );
  always #5 ap_clk = ~ap_clk;
  // core model: accepts a start, pulses ready after rdy_dly and done after done_dly cycles
  always @(posedge ap_clk) begin
    if (!ap_rst_n || !core_rst_n) begin
      mbusy <= 1'b0;
      cnt <= 0;
      core_ap_ready <= 1'b0;
      core_ap_done <= 1'b0;
    end else begin
      core_ap_ready <= 1'b0;
      core_ap_done <= 1'b0;
      if (!mbusy && core_ap_start) begin
        mbusy <= 1'b1;
        cnt <= 1;
        start_cnt <= start_cnt + 1;
      end else if (mbusy) begin
        cnt <= cnt + 1;
        if (cnt == rdy_dly) core_ap_ready <= 1'b1;
        if (!never_done && cnt == done_dly) begin
          core_ap_done <= 1'b1;
          mbusy <= 1'b0;
        end
      end
    end
  end
  assign core_ap_idle = !mbusy;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic wait_start(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!core_ap_start && n < 50);
    chk(tag, core_ap_start, 1);
  endtask
  task automatic wait_frame(input string tag);
    logic [15:0] last;
    int n = 0;
    int e;
    do begin last = frames_done; tick(); n++; end while (!(frames_done != last && frames_done != 0) && n < 200);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -1;
    chk(tag, frames_done, e);
  endtask
  task automatic wait_fault_hold(input string tag);
    int n = 0;
    while (!(fault && core_rst_n) && n < 100) begin tick(); n++; end
    chk(tag, {fault, core_rst_n}, 2'b11);
  endtask
  task automatic do_clear();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
  endtask
  function automatic int sat(input int v);
    return v >= 255 ? 255 : v + 1;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
  initial begin
    int n, s0;
    ap_rst_n = 1'b0; enable = 1'b0; clear_fault = 1'b0; deadlock_block = 1'b0;
    frame_limit = '0; timeout_cycles = '0;
    repeat (3) tick();
    chk("rst_start", core_ap_start, 0);
    chk("rst_rstn", core_rst_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_fault", {fault, fault_cause}, 0);
    chk("rst_err", error_count, 0);
    ap_rst_n = 1'b1;
    tick();
    frame_limit = 16'd3;
    s0 = start_cnt;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    enable = 1'b1;
    tick();
    chk("start_latency", core_ap_start, 1);
    chk("busy_start", busy, 1);
    wait_frame("frame1");
    chk("turnaround", core_ap_start, 1);
    wait_frame("frame2");
    wait_frame("frame3");
    enable = 1'b0;
    chk("limit_idle", busy, 0);
    repeat (5) tick();
    chk("limit_starts", start_cnt - s0, 3);
    chk("limit_nofault", fault, 0);
    chk("limit_frames_hold", frames_done, 3);
    frame_limit = 16'd1; timeout_cycles = 24'd22;
    exp_q.push_back(1);
    enable = 1'b1;
    wait_frame("race_frame");
    enable = 1'b0;
    chk("race_nofault", fault, 0);
    chk("race_cause", fault_cause, 0);
    chk("race_err", error_count, exp_err);
    repeat (3) tick();
    chk("race_idle", {busy, fault}, 0);
    frame_limit = '0; timeout_cycles = 24'd50; never_done = 1'b1;
    enable = 1'b1;
    wait_start("to_start");
    repeat (49) tick();
    chk("to_pre", core_rst_n, 1);
    tick();
    exp_err = sat(exp_err);
    chk("to_rst_fall", core_rst_n, 0);
    chk("to_cause", fault_cause, 2'b01);
    chk("to_err", error_count, exp_err);
    chk("to_fault", fault, 1);
    n = 0;
    while (!core_rst_n && n < 100) begin n++; tick(); end
    chk("to_rst_len", n, 8);
    repeat (5) tick();
    chk("to_hold", {fault, busy, core_ap_start, core_rst_n}, 4'b1001);
    chk("to_cause_hold", fault_cause, 2'b01);
    enable = 1'b0;
    do_clear();
    chk("to_clear", {fault, fault_cause, busy}, 0);
    timeout_cycles = '0;
    enable = 1'b1;
    wait_start("dl_start");
    deadlock_block = 1'b1;
    repeat (15) tick();
    deadlock_block = 1'b0;
    chk("dl_short", {fault, busy, core_rst_n}, 3'b011);
    repeat (3) tick();
    deadlock_block = 1'b1;
    repeat (15) tick();
    chk("dl_pre", core_rst_n, 1);
    tick();
    exp_err = sat(exp_err);
    chk("dl_fall", core_rst_n, 0);
    chk("dl_cause", fault_cause, 2'b10);
    chk("dl_err", error_count, exp_err);
    deadlock_block = 1'b0; enable = 1'b0;
    wait_fault_hold("dl_hold");
    do_clear();
    timeout_cycles = 24'd16;
    enable = 1'b1;
    wait_start("both_start");
    deadlock_block = 1'b1;
    repeat (16) tick();
    exp_err = sat(exp_err);
    chk("both_cause", fault_cause, 2'b11);
    chk("both_err", error_count, exp_err);
    deadlock_block = 1'b0; enable = 1'b0;
    wait_fault_hold("both_hold");
    do_clear();
    chk("both_clear", fault_cause, 0);
    timeout_cycles = '0; never_done = 1'b0;
    exp_q.push_back(1);
    enable = 1'b1;
    wait_start("drop_start");
    tick();
    enable = 1'b0;
    s0 = start_cnt;
    wait_frame("drop_frame");
    chk("drop_idle", busy, 0);
    repeat (30) tick();
    chk("drop_nostart", start_cnt - s0, 0);
    chk("drop_start_low", core_ap_start, 0);
    exp_q.push_back(1);
    enable = 1'b1;
    wait_frame("prerst_frame");
    repeat (8) tick();
    chk("prerst_busy", busy, 1);
    #3 ap_rst_n = 1'b0;
    #1;
    chk("arst_start", core_ap_start, 0);
    chk("arst_rstn", core_rst_n, 1);
    chk("arst_busy", busy, 0);
    chk("arst_frames", frames_done, 0);
    chk("arst_fault", {fault, fault_cause}, 0);
    chk("arst_err", error_count, 0);
    exp_err = 0; enable = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();
    timeout_cycles = 24'd1;
    for (int i = 0; i < 260; i++) begin
      enable = 1'b1;
      n = 0;
      while (!fault && n < 20) begin tick(); n++; end
      chk("sat_fire", fault, 1);
      enable = 1'b0;
      exp_err = sat(exp_err);
      wait_fault_hold("sat_hold");
      do_clear();
    end
    chk("sat_err", error_count, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
